// File: rtl/seq_frame_rx.sv
// seq_frame_rx: serial frame receiver.
// Hunts a HEAD_W-bit header on a strobed 1-bit stream. It then deserialises
// BYTE_NUM payload words and one checksum word (MSB first), and verifies the checksum.
// Optional macro SEQ_FRAME_RX_XOR_CHK_EN: checksum is the XOR of the payload
// words instead of their modulo-2^DATA_W sum.
module seq_frame_rx #(
  parameter int                HEAD_W   = 8,
  parameter logic [HEAD_W-1:0] HEAD_PAT = 8'hA5,
  parameter int                DATA_W   = 8,
  parameter int                BYTE_NUM = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_en,
  input  logic                       data_in,
  input  logic                       clr,
  output logic [BYTE_NUM*DATA_W-1:0] out_data,
  output logic                       out_valid,
  output logic                       out_check_flag,
  output logic                       out_err,
  output logic                       busy
);

  localparam int             BCW       = $clog2(DATA_W);
  localparam int             WCW       = $clog2(BYTE_NUM + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(BYTE_NUM);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state;
  logic [HEAD_W-1:0]          head_sr;
  logic [HEAD_W-1:0]          head_nxt;
  logic [BCW-1:0]             bit_cnt;
  logic [WCW-1:0]             word_cnt;
  logic [DATA_W-1:0]          sum;
  logic [DATA_W-1:0]          cur_word;
  logic [DATA_W-1:0]          word_nxt;
  logic [BYTE_NUM*DATA_W-1:0] pay_buf;
  logic                       word_done;

  // Running checksum update for one completed payload word; carry is dropped.
  function automatic logic [DATA_W-1:0] chk_acc(input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] w);
`ifdef SEQ_FRAME_RX_XOR_CHK_EN
    return acc ^ w;
`else
    return acc + w;
`endif
  endfunction

  assign head_nxt  = {head_sr[HEAD_W-2:0], data_in};
  assign word_nxt  = {cur_word[DATA_W-2:0], data_in};
  assign word_done = data_en && (bit_cnt == BIT_LAST);

  // Word deserialiser and payload store; cur_word holds the checksum word once RECV ends.
  always_ff @(posedge clk) begin
    if (state == RECV && data_en) begin
      cur_word <= word_nxt;
      if (word_done && word_cnt != WORD_LAST) begin
        pay_buf[int'(word_cnt)*DATA_W +: DATA_W] <= word_nxt;
      end
    end
  end

  // Control FSM: header hunt, bit/word counting, checksum and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= HUNT;
      head_sr        <= '0;
      bit_cnt        <= '0;
      word_cnt       <= '0;
      sum            <= '0;
      busy           <= 1'b0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_check_flag <= 1'b0;
      out_err        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      if (clr) begin
        // Abort: discard the partial frame, leave the last result on the outputs.
        state    <= HUNT;
        head_sr  <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        sum      <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (data_en) begin
              head_sr <= head_nxt;
              // Sliding-window compare, so overlapping prefixes are still found.
              if (head_nxt == HEAD_PAT) begin
                state    <= RECV;
                busy     <= 1'b1;
                bit_cnt  <= '0;
                word_cnt <= '0;
                sum      <= '0;
              end
            end
          end
          RECV: begin
            if (data_en) begin
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                if (word_cnt == WORD_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                end else begin
                  sum      <= chk_acc(sum, word_nxt);
                  word_cnt <= word_cnt + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          DONE: begin
            // Single cycle regardless of data_en; a bit offered here is dropped.
            out_data       <= pay_buf;
            out_check_flag <= (cur_word == sum);
            out_valid      <= 1'b1;
            out_err        <= (cur_word != sum);
            head_sr        <= '0;
            state          <= HUNT;
          end
          default: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_frame_rx.sv
// tb_seq_frame_rx: randomized self-checking bench for seq_frame_rx.
// Expected results come from the frame contents (payload sum/xor, header search
// over the sent bit string), not from the receiver's internal structure.
module tb_seq_frame_rx;

  localparam int          HEAD_W   = 8;
  localparam logic [7:0]  HEAD_PAT = 8'hA5;
  localparam int          DATA_W   = 8;
  localparam int          BYTE_NUM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_en = 1'b0;
  logic        data_in = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_check_flag;
  logic        out_err;
  logic        busy;

  int n_checks = 0;
  int n_pass = 0;
  int n_pulses = 0;
  int exp_pulses = 0;

  logic [7:0]  fr_pay [BYTE_NUM];
  logic [7:0]  fr_chk;
  logic [31:0] last_data = '0;
  logic        last_flag = 1'b0;

  always #5 clk = ~clk;

  seq_frame_rx #(
    .HEAD_W  (HEAD_W),
    .HEAD_PAT(HEAD_PAT),
    .DATA_W  (DATA_W),
    .BYTE_NUM(BYTE_NUM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_en       (data_en),
    .data_in       (data_in),
    .clr           (clr),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_check_flag(out_check_flag),
    .out_err       (out_err),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pulse counter and out_err-only-with-out_valid monitor.
  always @(negedge clk) begin
    if (out_valid) n_pulses++;
    if (out_err) check_eq("err_with_valid", out_valid, 1'b1);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference checksum over the current payload.
  function automatic logic [7:0] model_chk();
    logic [7:0] a;
    a = 8'h00;
    for (int k = 0; k < BYTE_NUM; k++) begin
`ifdef SEQ_FRAME_RX_XOR_CHK_EN
      a = a ^ fr_pay[k];
`else
      a = a + fr_pay[k];
`endif
    end
    return a;
  endfunction

  // True when the first header occurrence in (cleared reg + noise + header) ends at the header.
  function automatic bit noise_ok(input int n, input logic [15:0] nz);
    bit s[$];
    logic [7:0] w;
    for (int i = 0; i < HEAD_W; i++) s.push_back(1'b0);
    for (int i = n - 1; i >= 0; i--) s.push_back(nz[i]);
    for (int i = HEAD_W - 1; i >= 0; i--) s.push_back(HEAD_PAT[i]);
    for (int i = HEAD_W - 1; i < s.size(); i++) begin
      for (int j = 0; j < HEAD_W; j++) w[HEAD_W-1-j] = s[i-HEAD_W+1+j];
      if (w == HEAD_PAT) return (i == s.size() - 1);
    end
    return 1'b0;
  endfunction

  task automatic idle_cycle();
    data_en = 1'b0;
    data_in = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous, mode 1: 1-0-0 strobe, mode 2: random 0..3 idle cycles per bit.
  task automatic drive_bit(input logic b, input int mode);
    int idle;
    data_in = b;
    data_en = 1'b1;
    @(posedge clk);
    #1;
    data_en = 1'b0;
    idle = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
    repeat (idle) idle_cycle();
  endtask

  task automatic send_frame(input int mode, input int gap_at, input int nz_n, input logic [15:0] nz);
    logic [7:0]  exp_chk;
    logic [31:0] exp_data;
    bit          good;
    exp_chk = model_chk();
    good = (fr_chk == exp_chk);
    for (int k = 0; k < BYTE_NUM; k++) exp_data[k*8 +: 8] = fr_pay[k];
    for (int i = nz_n - 1; i >= 0; i--) drive_bit(nz[i], mode);
    for (int i = HEAD_W - 1; i >= 0; i--) drive_bit(HEAD_PAT[i], mode);
    check_eq("busy_after_header", busy, 1'b1);
    for (int k = 0; k < BYTE_NUM; k++) begin
      if (k == gap_at) begin
        repeat (20) idle_cycle();
        check_eq("busy_in_gap", busy, 1'b1);
      end
      for (int b = 7; b >= 0; b--) drive_bit(fr_pay[k][b], mode);
    end
    for (int b = 7; b >= 1; b--) drive_bit(fr_chk[b], mode);
    drive_bit(fr_chk[0], 0);
    check_eq("valid_before_done", out_valid, 1'b0);
    check_eq("busy_after_last", busy, 1'b0);
    // Junk bit offered during the DONE cycle must be ignored.
    data_en = 1'b1;
    data_in = 1'($urandom);
    @(posedge clk);
    #1;
    data_en = 1'b0;
    exp_pulses++;
    check_eq("valid_pulse", out_valid, 1'b1);
    check_eq("out_data", out_data, exp_data);
    check_eq("check_flag", out_check_flag, good);
    check_eq("err_pulse", out_err, !good);
    @(posedge clk);
    #1;
    check_eq("valid_one_cycle", out_valid, 1'b0);
    check_eq("err_one_cycle", out_err, 1'b0);
    check_eq("pulse_count", n_pulses, exp_pulses);
    check_eq("flag_held", out_check_flag, good);
    last_data = exp_data;
    last_flag = good;
  endtask

  task automatic abort_frame(input int nbytes, input bit use_rst);
    for (int i = HEAD_W - 1; i >= 0; i--) drive_bit(HEAD_PAT[i], 0);
    for (int k = 0; k < nbytes; k++)
      for (int b = 7; b >= 0; b--) drive_bit(fr_pay[k][b], 0);
    check_eq("busy_before_abort", busy, 1'b1);
    data_en = 1'b1;
    data_in = 1'b1;
    if (use_rst) rst_n = 1'b0;
    else clr = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr = 1'b0;
    data_en = 1'b0;
    if (use_rst) begin
      last_data = '0;
      last_flag = 1'b0;
    end
    check_eq("busy_after_abort", busy, 1'b0);
    repeat (10) idle_cycle();
    check_eq("abort_no_pulse", n_pulses, exp_pulses);
    check_eq("abort_out_data", out_data, last_data);
    check_eq("abort_flag", out_check_flag, last_flag);
    check_eq("abort_valid", out_valid, 1'b0);
  endtask

  initial begin
    int          mode;
    int          gap_at;
    int          nz_n;
    logic [15:0] nz;

    rst_n = 1'b0;
    repeat (3) begin
      data_en = 1'($urandom);
      data_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
    data_en = 1'b0;
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_flag", out_check_flag, 1'b0);
    check_eq("rst_err", out_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle_cycle();

    // Good frame, continuous strobe.
    fr_pay = '{8'h12, 8'h34, 8'h56, 8'h78};
    fr_chk = model_chk();
    send_frame(0, -1, 0, 16'h0);

    // Bad checksum.
`ifdef SEQ_FRAME_RX_XOR_CHK_EN
    fr_chk = 8'h14;
`else
    fr_chk = 8'h15;
`endif
    send_frame(0, -1, 0, 16'h0);

    // Good frame, 1-0-0 strobe and a 20-cycle gap mid-payload.
    fr_chk = model_chk();
    send_frame(1, 2, 0, 16'h0);

    // Noise 1,0,1 before the header, then a back-to-back wrapping frame.
    send_frame(0, -1, 3, 16'b101);
    fr_pay = '{8'hFF, 8'h01, 8'h00, 8'h00};
    fr_chk = model_chk();
    send_frame(0, -1, 0, 16'h0);

    // clr after two payload words, reset during a later frame, then a clean frame.
    fr_pay = '{8'h12, 8'h34, 8'h56, 8'h78};
    abort_frame(2, 1'b0);
    abort_frame(3, 1'b1);
    fr_chk = model_chk();
    send_frame(2, 1, 0, 16'h0);

    // Randomized frames with noise, strobe patterns and good/bad checksums.
    repeat (25) begin
      for (int k = 0; k < BYTE_NUM; k++) fr_pay[k] = 8'($urandom);
      fr_chk = model_chk();
      if ($urandom_range(0, 3) == 0) fr_chk = fr_chk ^ 8'($urandom_range(1, 255));
      mode = int'($urandom_range(0, 2));
      gap_at = int'($urandom_range(0, 6));
      do begin
        nz_n = int'($urandom_range(0, 12));
        nz = 16'($urandom);
      end while (!noise_ok(nz_n, nz));
      send_frame(mode, gap_at, nz_n, nz);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
